rv32i_dmem: RTL and testbench

Data-memory responder for the RV32I core's load/store port. Accepts one request at a time over a valid/ready handshake. Holds it for a programmable number of wait states, then commits stores with byte-lane masking or returns loads with sign/zero extension. Sits between the core's memory-access stage and the on-chip data RAM, and is the slave end of the core's address/write-data/write-enable interface.

---
 rtl/dmem_pkg.sv | 44 ++++
 rtl/dmem_lane_align.sv | 59 +++++
 rtl/rv32i_dmem.sv | 146 ++++++++++++++
 tb/tb_rv32i_dmem.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared definitions for the rv32i_dmem data-memory responder:
//            access-size encodings, FSM state type, lane count and small
//            address helpers.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // req_size encodings (2'b11 is handled as a word access)
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Byte lanes in one 32-bit word (width of the byte-enable mask)
  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Half on an odd byte, or word off a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return lane[0];
      default: return (lane != 2'b00);
    endcase
  endfunction

  // Clears the low address bits a given size cannot address.
  function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_B:  return lane;
      SIZE_H:  return {lane[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Purpose  : Combinational lane steering for the data memory.
//            Store side: byte-enable mask plus data replicated across lanes.
//            Load side : selects byte/half by lane and sign/zero extends.
// Ports    : size        access size (SIZE_B/SIZE_H/SIZE_W, 11 = word)
//            lane        byte offset within the word (already aligned)
//            is_unsigned zero-extend loads (ignored for words)
//            wdata       right-aligned store data
//            rword       raw word read from the array
//            be          per-lane write enables
//            wword       store data positioned on all lanes
//            rdata       extended load result
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]       size,
  input  logic [1:0]       lane,
  input  logic             is_unsigned,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rword,
  output logic [LANES-1:0] be,
  output logic [31:0]      wword,
  output logic [31:0]      rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be       = '1;
    wword    = wdata;
    rdata    = rword;
    byte_sel = rword[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? rword[31:16] : rword[15:0];
    case (size)
      SIZE_B: begin
        be    = LANES'(1) << lane;
        wword = {4{wdata[7:0]}};
        rdata = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SIZE_H: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        be    = '1;
        wword = wdata;
        rdata = rword;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv32i_dmem.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_dmem
// Purpose  : Data-memory responder for the RV32I load/store port. Accepts one
//            request at a time, waits WAIT_STATES cycles, then commits a
//            byte-masked store or returns an extended load.
// Ports    : clk/rst_n                 clock, async active-low reset
//            req_valid/req_ready       request handshake (ready registered)
//            req_we/addr/wdata/size/unsigned  request fields
//            rsp_valid                 one-cycle response strobe
//            rsp_rdata/rsp_err         load data / misalign flag, held
// Config   : DMEM_MISALIGN_ERR_EN - when defined, misaligned half/word
//            accesses return rsp_err=1 with no write; otherwise the low
//            address bits are forced to alignment and rsp_err stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_dmem
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             we_q, uns_q, err_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lane_q, size_q;
  logic [31:0]      wdata_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept, access, do_write;
  logic [LANES-1:0] be;
  logic [31:0]      wword, ld_data, rword;
  logic             unused_addr;

  // Upper address bits only wrap the space; they are deliberately dropped.
  assign unused_addr = ^req_addr;

  assign accept = (state == IDLE) && req_valid && req_ready;
  // WAIT is always visited once; it holds for WAIT_STATES extra cycles so
  // the array access lands WAIT_STATES+1 edges after acceptance.
  assign access   = (state == WAIT) && (cnt == '0);
  assign do_write = access && we_q && !err_q;
  assign rword    = mem[idx_q];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = WAIT;
      WAIT:    if (cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef DMEM_MISALIGN_ERR_EN
  logic err_d;
  logic [1:0] lane_d;
  assign err_d  = is_misaligned(req_size, req_addr[1:0]);
  assign lane_d = req_addr[1:0];
`else
  logic err_d;
  logic [1:0] lane_d;
  assign err_d  = 1'b0;
  assign lane_d = align_lane(req_size, req_addr[1:0]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      lane_q    <= 2'b00;
      size_q    <= SIZE_W;
      wdata_q   <= 32'h0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      // Outputs are registered from the next state so they line up with it.
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
      if (accept) begin
        cnt     <= CNT_W'(WAIT_STATES);
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= err_d;
        idx_q   <= req_addr[2 +: IDX_W];
        lane_q  <= lane_d;
        size_q  <= req_size;
        wdata_q <= req_wdata;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (access) begin
        rsp_rdata <= (we_q || err_q) ? 32'h0 : ld_data;
        rsp_err   <= err_q;
      end
    end
  end

  // Array is not reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[idx_q][i*8 +: 8] <= wword[i*8 +: 8];
      end
    end
  end

  dmem_lane_align u_align (
    .size        (size_q),
    .lane        (lane_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rword       (rword),
    .be          (be),
    .wword       (wword),
    .rdata       (ld_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_rv32i_dmem.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_dmem
// Purpose  : Self-checking bench for rv32i_dmem. DUT "a" uses WAIT_STATES=1,
//            DUT "b" uses WAIT_STATES=0. A byte-addressed reference memory
//            predicts load data and error flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_dmem;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid = 0, a_ready, a_we = 0, a_uns = 0, a_rv, a_err;
  logic [31:0] a_addr = 0, a_wdata = 0, a_rdata;
  logic [1:0]  a_size = 0;
  logic        b_valid = 0, b_ready, b_we = 0, b_uns = 0, b_rv, b_err;
  logic [31:0] b_addr = 0, b_wdata = 0, b_rdata;
  logic [1:0]  b_size = 0;

  int tests = 0;
  int fails = 0;

  logic [7:0] mb [4096];  // reference bytes for DUT a (1024 words)

  rv32i_dmem #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .ADDR_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
    .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata), .req_size(a_size),
    .req_unsigned(a_uns), .rsp_valid(a_rv), .rsp_rdata(a_rdata), .rsp_err(a_err));

  rv32i_dmem #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .ADDR_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata), .req_size(b_size),
    .req_unsigned(b_uns), .rsp_valid(b_rv), .rsp_rdata(b_rdata), .rsp_err(b_err));

  function automatic logic rdy(input bit sel);
    return sel ? b_ready : a_ready;
  endfunction
  function automatic logic rvl(input bit sel);
    return sel ? b_rv : a_rv;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] sz, input logic uns);
    if (sel) begin
      b_valid = v; b_we = we; b_addr = addr; b_wdata = wd; b_size = sz; b_uns = uns;
    end else begin
      a_valid = v; a_we = we; a_addr = addr; a_wdata = wd; a_size = sz; a_uns = uns;
    end
  endtask

  // One request; lat = edges from accept to rsp_valid seen, busy = edges
  // from accept until req_ready seen high again, hold = rsp_valid one edge later.
  task automatic txn(input bit sel, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [1:0] sz, input logic uns, output logic [31:0] rdata,
                     output logic err, output int lat, output int busy, output logic hold);
    int guard;
    @(negedge clk);
    drive(sel, 1'b1, we, addr, wd, sz, uns);
    guard = 0;
    while (rdy(sel) !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    lat = -1; busy = -1; rdata = 32'hx; err = 1'bx; hold = 1'bx;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      if (lat > 0 && k == lat + 1) hold = rvl(sel);
      if (lat < 0 && rvl(sel) === 1'b1) begin
        lat   = k;
        rdata = sel ? b_rdata : a_rdata;
        err   = sel ? b_err : a_err;
      end
      if (busy < 0 && rdy(sel) === 1'b1) busy = k;
      if (lat > 0 && busy > 0 && k > lat) break;
    end
  endtask

  // Reference model: byte-addressed, wraps modulo 4 KiB.
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [1:0] sz, input logic uns,
                              output logic [31:0] exp_rd, output logic exp_err);
    int nb, ea;
    logic [31:0] v;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    ea = int'(addr % 4096);
    exp_rd = 32'h0;
    exp_err = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
    if (ea % nb != 0) begin
      exp_err = 1'b1;
      return;
    end
`else
    ea = ea - (ea % nb);
`endif
    if (we) begin
      for (int i = 0; i < nb; i++) mb[ea + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(mb[ea + i]) << (8 * i));
      if (nb < 4 && !uns && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      exp_rd = v;
    end
  endtask

  task automatic test_reset();
    #1;
    if (a_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", a_ready); end
    tests++;
    if (a_rv !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", a_rv); end
    tests++;
    if (a_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", a_rdata); end
    tests++;
    if (a_err !== 1'b0 || b_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b/%b want 0", a_err, b_err); end
    tests++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    if (a_ready !== 1'b0) begin fails++; $display("FAIL ready_before_edge: got %b want 0", a_ready); end
    tests++;
    @(posedge clk);
    #1;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      fails++; $display("FAIL ready_after_release: got %b/%b want 1", a_ready, b_ready);
    end
    tests++;
  endtask

  task automatic test_word_timing();
    logic [31:0] rd, erd; logic er, eer, h; int lat, busy;
    model_access(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, erd, eer);
    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, er, lat, busy, h);
    if (lat !== 2 || busy !== 3 || h !== 1'b0) begin
      fails++; $display("FAIL sw_timing: got lat=%0d busy=%0d hold=%b want 2 3 0", lat, busy, h);
    end
    tests++;
    if (rd !== 32'h0 || er !== 1'b0) begin fails++; $display("FAIL sw_rsp: got %h err=%b want 0 0", rd, er); end
    tests++;
    txn(1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat, busy, h);
    if (rd !== 32'hDEADBEEF || lat !== 2 || busy !== 3) begin
      fails++; $display("FAIL lw_10: got %h lat=%0d busy=%0d want deadbeef 2 3", rd, lat, busy);
    end
    tests++;
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd, erd; logic er, eer, h; int lat, busy;
    model_access(1'b1, 32'h11, 32'h55, 2'b00, 1'b0, erd, eer);
    txn(1'b0, 1'b1, 32'h11, 32'h55, 2'b00, 1'b0, rd, er, lat, busy, h);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat, busy, h);
    if (rd !== 32'hDEAD55EF) begin fails++; $display("FAIL sb_merge: got %h want dead55ef", rd); end
    tests++;
    txn(1'b0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, rd, er, lat, busy, h);
    if (rd !== 32'hFFFFFFDE) begin fails++; $display("FAIL lb_13: got %h want ffffffde", rd); end
    tests++;
    txn(1'b0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, rd, er, lat, busy, h);
    if (rd !== 32'h000000DE) begin fails++; $display("FAIL lbu_13: got %h want 000000de", rd); end
    tests++;
  endtask

  task automatic test_halves();
    logic [31:0] rd, erd; logic er, eer, h; int lat, busy;
    model_access(1'b1, 32'h20, 32'h80017FFF, 2'b10, 1'b0, erd, eer);
    txn(1'b0, 1'b1, 32'h20, 32'h80017FFF, 2'b10, 1'b0, rd, er, lat, busy, h);
    txn(1'b0, 1'b0, 32'h22, 32'h0, 2'b01, 1'b0, rd, er, lat, busy, h);
    if (rd !== 32'hFFFF8001) begin fails++; $display("FAIL lh_22: got %h want ffff8001", rd); end
    tests++;
    txn(1'b0, 1'b0, 32'h22, 32'h0, 2'b01, 1'b1, rd, er, lat, busy, h);
    if (rd !== 32'h00008001) begin fails++; $display("FAIL lhu_22: got %h want 00008001", rd); end
    tests++;
    txn(1'b0, 1'b0, 32'h20, 32'h0, 2'b01, 1'b0, rd, er, lat, busy, h);
    if (rd !== 32'h00007FFF) begin fails++; $display("FAIL lh_20: got %h want 00007fff", rd); end
    tests++;
  endtask

  task automatic test_wrap();
    logic [31:0] rd, erd; logic er, eer, h; int lat, busy;
    model_access(1'b1, 32'h1000, 32'h12345678, 2'b10, 1'b0, erd, eer);
    txn(1'b0, 1'b1, 32'h1000, 32'h12345678, 2'b10, 1'b0, rd, er, lat, busy, h);
    txn(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, rd, er, lat, busy, h);
    if (rd !== 32'h12345678) begin fails++; $display("FAIL wrap_lw0: got %h want 12345678", rd); end
    tests++;
  endtask

  task automatic test_misalign();
    logic [31:0] rd, erd, exp_word; logic er, eer, h, exp_err; int lat, busy;
    model_access(1'b1, 32'h40, 32'h11111111, 2'b10, 1'b0, erd, eer);
    txn(1'b0, 1'b1, 32'h40, 32'h11111111, 2'b10, 1'b0, rd, er, lat, busy, h);
    model_access(1'b1, 32'h42, 32'hCAFEF00D, 2'b10, 1'b0, erd, eer);
    txn(1'b0, 1'b1, 32'h42, 32'hCAFEF00D, 2'b10, 1'b0, rd, er, lat, busy, h);
`ifdef DMEM_MISALIGN_ERR_EN
    exp_err = 1'b1; exp_word = 32'h11111111;
`else
    exp_err = 1'b0; exp_word = 32'hCAFEF00D;
`endif
    if (er !== exp_err || rd !== 32'h0 || lat !== 2) begin
      fails++; $display("FAIL misalign_sw: got err=%b rd=%h lat=%0d want err=%b rd=0 lat=2", er, rd, lat, exp_err);
    end
    tests++;
    txn(1'b0, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, rd, er, lat, busy, h);
    if (rd !== exp_word || er !== 1'b0) begin
      fails++; $display("FAIL misalign_word40: got %h err=%b want %h 0", rd, er, exp_word);
    end
    tests++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic er, eer, h, saw; int lat, busy, guard;
    model_access(1'b1, 32'h30, 32'hAAAA5555, 2'b10, 1'b0, erd, eer);
    txn(1'b0, 1'b1, 32'h30, 32'hAAAA5555, 2'b10, 1'b0, rd, er, lat, busy, h);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h0BADF00D, 2'b10, 1'b0);
    guard = 0;
    while (a_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    #1;
    rst_n = 1'b0;
    saw = 1'b0;
    @(posedge clk);
    #1;
    saw = saw | a_rv;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    if (a_ready !== 1'b0) begin fails++; $display("FAIL midrst_ready_low: got %b want 0", a_ready); end
    tests++;
    @(posedge clk);
    #1;
    if (a_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready_high: got %b want 1", a_ready); end
    tests++;
    for (int k = 0; k < 5; k++) begin
      saw = saw | a_rv;
      @(posedge clk);
      #1;
    end
    if (saw !== 1'b0) begin fails++; $display("FAIL midrst_no_rsp: got rsp_valid=%b want 0", saw); end
    tests++;
    txn(1'b0, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0, rd, er, lat, busy, h);
    if (rd !== 32'hAAAA5555) begin fails++; $display("FAIL midrst_word30: got %h want aaaa5555", rd); end
    tests++;
  endtask

  task automatic test_back_to_back();
    logic r;
    int acc [$];
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h50, 32'h5A5A0F0F, 2'b10, 1'b0);
    for (int t = 0; t < 13; t++) begin
      r = a_ready;
      @(posedge clk);
      if (r === 1'b1) acc.push_back(t);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    for (int t = 0; t < 6; t++) @(posedge clk);
    begin
      logic [31:0] erd; logic eer;
      model_access(1'b1, 32'h50, 32'h5A5A0F0F, 2'b10, 1'b0, erd, eer);
    end
    if (acc.size() < 3 || acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin
      fails++; $display("FAIL back_to_back: got %0d accepts, spacing %0d want >=3 spacing 4",
                        acc.size(), (acc.size() > 1) ? acc[1] - acc[0] : -1);
    end
    tests++;
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; logic er, h; int lat, busy;
    txn(1'b1, 1'b1, 32'h8, 32'hA5C3_1E0F, 2'b10, 1'b0, rd, er, lat, busy, h);
    if (lat !== 1 || busy !== 2 || h !== 1'b0) begin
      fails++; $display("FAIL ws0_timing: got lat=%0d busy=%0d hold=%b want 1 2 0", lat, busy, h);
    end
    tests++;
    txn(1'b1, 1'b0, 32'h8, 32'h0, 2'b10, 1'b0, rd, er, lat, busy, h);
    if (rd !== 32'hA5C3_1E0F || lat !== 1) begin
      fails++; $display("FAIL ws0_lw: got %h lat=%0d want a5c31e0f 1", rd, lat);
    end
    tests++;
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, wd; logic er, eer, h, we, uns; logic [1:0] sz; int lat, busy;
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      model_access(1'b1, 32'h100 + 32'(4 * w), wd, 2'b10, 1'b0, erd, eer);
      txn(1'b0, 1'b1, 32'h100 + 32'(4 * w), wd, 2'b10, 1'b0, rd, er, lat, busy, h);
    end
    for (int n = 0; n < 40; n++) begin
      addr = (32'h100 + 32'($urandom_range(0, 63))) | ($urandom & 32'hFFFF_F000);
      wd   = $urandom;
      sz   = 2'($urandom_range(0, 3));
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      model_access(we, addr, wd, sz, uns, erd, eer);
      txn(1'b0, we, addr, wd, sz, uns, rd, er, lat, busy, h);
      if (rd !== erd || er !== eer || lat !== 2) begin
        fails++;
        $display("FAIL rand_%0d: we=%b addr=%h sz=%0d uns=%b got rd=%h err=%b lat=%0d want rd=%h err=%b lat=2",
                 n, we, addr, sz, uns, rd, er, lat, erd, eer);
      end
      tests++;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_word_timing();
    test_byte_lanes();
    test_halves();
    test_wrap();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    test_zero_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
`default_nettype wire
